// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the external memory bus arbiter: FSM state encodings
// and master ids.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_CORE  = 1'b0,
    ARB_OWNER_DEBUG = 1'b1
  } arb_owner_e;

  localparam int ARB_WAIT_MAX = 15;

endpackage

// File: rtl/bus_arb_wait_counter.sv
// Wait-state and timeout counting for the ACCESS phase of the bus arbiter.
// Timeout counting exists only when BUS_ARB_TIMEOUT_EN is defined.
module bus_arb_wait_counter
  import bus_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wait_ok,
  output logic timeout
);

  logic [3:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (clr)
      wcnt_d = '0;
    else if (en && (32'(wcnt_q) != ARB_WAIT_MAX))
      wcnt_d = wcnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wcnt_q <= '0;
    else     wcnt_q <= wcnt_d;
  end

  assign wait_ok = (32'(wcnt_q) >= WAIT_STATES);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt_q, tcnt_d;

  // Flag goes high during the TIMEOUT-th ACCESS cycle so DONE follows it.
  always_comb begin
    tcnt_d = tcnt_q;
    if (clr)
      tcnt_d = '0;
    else if (en && (32'(tcnt_q) < TIMEOUT - 1))
      tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end

  assign timeout = en && (32'(tcnt_q) >= TIMEOUT - 1);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (core / debug) arbiter for the external memory bus with wait
// states, MEM_READY stretching and optional timeout abort (BUS_ARB_TIMEOUT_EN).
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          C_REQ,
  input  logic          C_RD,
  input  logic          C_WR0,
  input  logic          C_WR1,
  input  logic [AW-1:0] C_ADDR,
  input  logic [DW-1:0] C_DOUT,
  output logic          C_ACK,
  input  logic          D_REQ,
  input  logic          D_RD,
  input  logic          D_WR0,
  input  logic          D_WR1,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_DOUT,
  output logic          D_ACK,
  output logic [DW-1:0] RDATA,
  output logic          CORE_STALL,
  output logic [AW-1:0] ADDR_BUF,
  output logic [DW-1:0] DOUT_BUF,
  output logic          RD_BUF,
  output logic          WR0_BUF,
  output logic          WR1_BUF,
  input  logic [DW-1:0] DIN_BUF,
  input  logic          MEM_READY,
  output logic          BUS_ERR
);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  arb_owner_e    last_grant_q, last_grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rd_q, rd_d, wr0_q, wr0_d, wr1_q, wr1_d;

  logic any_req, pick_debug, cnt_clr, cnt_en, wait_ok, timeout;
  logic complete, abort;

  assign any_req = C_REQ | D_REQ;
  // Round-robin only matters on contention; a lone requester always wins.
  assign pick_debug = D_REQ && (!C_REQ || (last_grant_q != ARB_OWNER_DEBUG));

  bus_arb_wait_counter #(
    .WAIT_STATES(WAIT_STATES),
    .TIMEOUT    (TIMEOUT)
  ) u_wait (
    .clk    (CLK),
    .rst    (RESET),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .wait_ok(wait_ok),
    .timeout(timeout)
  );

  assign complete = (state_q == ARB_ACCESS) && wait_ok && MEM_READY;
  assign abort    = (state_q == ARB_ACCESS) && !complete && timeout;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (any_req) state_d = ARB_ACCESS;
      ARB_ACCESS: if (complete || abort) state_d = ARB_DONE;
      ARB_DONE:   state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    C_ACK   = 1'b0;
    D_ACK   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ARB_IDLE:   cnt_clr = any_req;
      ARB_ACCESS: cnt_en  = 1'b1;
      ARB_DONE: begin
        C_ACK = (owner_q == ARB_OWNER_CORE);
        D_ACK = (owner_q == ARB_OWNER_DEBUG);
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    rdata_d      = rdata_q;
    rd_d         = rd_q;
    wr0_d        = wr0_q;
    wr1_d        = wr1_q;
    if ((state_q == ARB_IDLE) && any_req) begin
      owner_d = pick_debug ? ARB_OWNER_DEBUG : ARB_OWNER_CORE;
      addr_d  = pick_debug ? D_ADDR : C_ADDR;
      dout_d  = pick_debug ? D_DOUT : C_DOUT;
      rd_d    = pick_debug ? D_RD   : C_RD;
      wr0_d   = pick_debug ? D_WR0  : C_WR0;
      wr1_d   = pick_debug ? D_WR1  : C_WR1;
    end
    if (complete || abort) begin
      rd_d  = 1'b0;
      wr0_d = 1'b0;
      wr1_d = 1'b0;
      if (abort)     rdata_d = '1;
      else if (rd_q) rdata_d = DIN_BUF;
    end
    if (state_q == ARB_DONE) last_grant_d = owner_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_q      <= ARB_OWNER_CORE;
      last_grant_q <= ARB_OWNER_CORE;
      addr_q       <= '0;
      dout_q       <= '0;
      rdata_q      <= '0;
      rd_q         <= 1'b0;
      wr0_q        <= 1'b0;
      wr1_q        <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      rdata_q      <= rdata_d;
      rd_q         <= rd_d;
      wr0_q        <= wr0_d;
      wr1_q        <= wr1_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (abort)                      err_d = 1'b1;
    else if (state_q == ARB_DONE)   err_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign BUS_ERR = (state_q == ARB_DONE) && err_q;
`else
  assign BUS_ERR = 1'b0;
`endif

  assign CORE_STALL = C_REQ & ~C_ACK;
  assign ADDR_BUF   = addr_q;
  assign DOUT_BUF   = dout_q;
  assign RD_BUF     = rd_q;
  assign WR0_BUF    = wr0_q;
  assign WR1_BUF    = wr1_q;
  assign RDATA      = rdata_q;

endmodule
